// File: rtl/fb_pkg.sv
// Shared constants, helpers and types for the frame-buffer compositor.
package fb_pkg;

  // Colour enum values with a fixed meaning to the compositor.
  localparam logic [3:0]       COL_BG    = 4'h0;
  localparam logic [3:0]       COL_WALL  = 4'h8;
  // Trail colour of player p is COL_TRAIL[p].
  localparam logic [3:0][3:0]  COL_TRAIL = {4'h9, 4'h6, 4'h5, 4'h3};

  // Linear pixel index width (covers 640*480) and widest supported colour enum.
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned PIX_MAX = 8;

  // Pixels packed per RAM word.
  function automatic int unsigned fb_ppw(input int unsigned word_bits,
                                         input int unsigned pix_bits);
    return word_bits / pix_bits;
  endfunction

  // RAM word address width for a given resolution and packing.
  function automatic int unsigned fb_ram_aw(input int unsigned h_res,
                                            input int unsigned v_res,
                                            input int unsigned ppw);
    return $clog2(h_res * v_res / ppw);
  endfunction

  localparam int unsigned PPW    = fb_ppw(16, 4);
  localparam int unsigned RAM_AW = fb_ram_aw(640, 480, PPW);

  // One queued trail-pixel write.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [PIX_MAX-1:0] pix;
  } wr_entry_t;

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous frame RAM: 1-cycle read latency, per-lane write enable.
module fb_ram #(
  parameter int unsigned Depth    = 76800,
  parameter int unsigned AddrW    = 17,
  parameter int unsigned Lanes    = 4,
  parameter int unsigned LaneBits = 4
) (
  input  logic                      clk_i,
  input  logic [AddrW-1:0]          addr_i,
  input  logic [Lanes-1:0]          be_i,
  input  logic [Lanes*LaneBits-1:0] wdata_i,
  output logic [Lanes*LaneBits-1:0] rdata_o
);

  logic [Lanes*LaneBits-1:0] mem [Depth];
  logic [Lanes*LaneBits-1:0] rdata_q;

  // Lane-masked write and registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < int'(Lanes); l++) begin
      if (be_i[l]) begin
        mem[addr_i][l*LaneBits +: LaneBits] <= wdata_i[l*LaneBits +: LaneBits];
      end
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_compositor.sv
// Frame-buffer compositor: packed frame RAM + write FIFO, per-pixel bike overlay
// with lowest-index priority and per-frame collision reporting.
// Optional trail-owner output is enabled by defining FB_OWNER_EN.
module fb_compositor
  import fb_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned PIX_BITS    = 4,
  parameter int unsigned WORD_BITS   = 16,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_clk,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic                            de,
  input  logic [NUM_PLAYERS-1:0]          bike_hit,
  input  logic [NUM_PLAYERS*PIX_BITS-1:0] bike_enum,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [18:0]                     wr_pix_addr,
  input  logic [PIX_BITS-1:0]             wr_pix,
  output logic [PIX_BITS-1:0]             color_enum,
  output logic                            pix_valid,
  output logic [NUM_PLAYERS-1:0]          collision,
  output logic [2:0]                      owner
);

  localparam int unsigned PPW_L     = fb_ppw(WORD_BITS, PIX_BITS);
  localparam int unsigned NUM_PIX   = H_RES * V_RES;
  localparam int unsigned RAM_DEPTH = NUM_PIX / PPW_L;
  localparam int unsigned RAM_AW_L  = fb_ram_aw(H_RES, V_RES, PPW_L);
  localparam int unsigned LANE_W    = (PPW_L > 1) ? $clog2(PPW_L) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);

  // ---------------- write FIFO ----------------
  wr_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, push, pop;
  wr_entry_t        head;

  // Handshake and pointer/count bookkeeping; pops only while the display is blanked.
  always_comb begin
    full     = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    empty    = (count_q == '0);
    push     = wr_valid && !full;
    pop      = !de && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  assign wr_ready = !full;
  assign head     = fifo_mem[rd_ptr_q];

  // FIFO storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: wr_pix_addr, pix: PIX_MAX'(wr_pix)};
  end

  // FIFO pointers and count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- RAM port arbitration ----------------
  logic [ADDR_W-1:0]         rd_idx;
  logic [RAM_AW_L-1:0]       rd_word, wr_word, ram_addr;
  logic [LANE_W-1:0]         rd_lane, wr_lane;
  logic                      wr_in_range;
  logic [PPW_L-1:0]          ram_be;
  logic [WORD_BITS-1:0]      ram_wdata, ram_rdata;
  logic                      unused_head_pix;

  // Read has the port during display; out-of-range queued writes pop without writing.
  always_comb begin
    rd_idx      = ADDR_W'(DrawY) * ADDR_W'(H_RES) + ADDR_W'(DrawX);
    rd_word     = RAM_AW_L'(rd_idx / ADDR_W'(PPW_L));
    rd_lane     = LANE_W'(rd_idx % ADDR_W'(PPW_L));
    wr_word     = RAM_AW_L'(head.addr / ADDR_W'(PPW_L));
    wr_lane     = LANE_W'(head.addr % ADDR_W'(PPW_L));
    wr_in_range = (head.addr < ADDR_W'(NUM_PIX));
    ram_addr    = de ? rd_word : wr_word;
    ram_be      = (pop && wr_in_range) ? (PPW_L'(1) << wr_lane) : '0;
    ram_wdata   = {PPW_L{head.pix[PIX_BITS-1:0]}};
  end

  assign unused_head_pix = ^head.pix;

  fb_ram #(
    .Depth    (RAM_DEPTH),
    .AddrW    (RAM_AW_L),
    .Lanes    (PPW_L),
    .LaneBits (PIX_BITS)
  ) u_ram (
    .clk_i   (Clk),
    .addr_i  (ram_addr),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // ---------------- pixel pipeline ----------------
  logic [LANE_W-1:0]               lane_q;
  logic                            de1_q, frame_clk_q;
  logic [NUM_PLAYERS-1:0]          hit1_q;
  logic [NUM_PLAYERS*PIX_BITS-1:0] enum1_q;
  logic [PIX_BITS-1:0]             frame_pix, bike_pix, color_d, color_q;
  logic [NUM_PLAYERS-1:0]          hits_now, sticky_d, sticky_q, collision_d, collision_q;
  logic                            pv_q, frame_edge;

  // Overlay, collision detection and frame-boundary reporting at the RAM-data stage.
  always_comb begin
    frame_pix  = ram_rdata[lane_q*PIX_BITS +: PIX_BITS];
    bike_pix   = '0;
    // Descending scan so the lowest hit index wins.
    for (int p = int'(NUM_PLAYERS) - 1; p >= 0; p--) begin
      if (hit1_q[p]) bike_pix = enum1_q[p*PIX_BITS +: PIX_BITS];
    end
    color_d = !de1_q ? '0 : ((|hit1_q) ? bike_pix : frame_pix);
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      hits_now[p] = de1_q && hit1_q[p] &&
                    ((frame_pix != PIX_BITS'(COL_BG)) ||
                     (|(hit1_q & ~(NUM_PLAYERS'(1) << p))));
    end
    frame_edge  = frame_clk && !frame_clk_q;
    sticky_d    = sticky_q | hits_now;
    collision_d = collision_q;
    if (frame_edge) begin
      collision_d = sticky_q | hits_now;
      sticky_d    = '0;
    end
  end

  // Sideband pipeline, registered outputs and collision state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lane_q      <= '0;
      de1_q       <= 1'b0;
      hit1_q      <= '0;
      enum1_q     <= '0;
      frame_clk_q <= 1'b0;
      color_q     <= '0;
      pv_q        <= 1'b0;
      sticky_q    <= '0;
      collision_q <= '0;
    end else begin
      lane_q      <= rd_lane;
      de1_q       <= de;
      hit1_q      <= bike_hit;
      enum1_q     <= bike_enum;
      frame_clk_q <= frame_clk;
      color_q     <= color_d;
      pv_q        <= de1_q;
      sticky_q    <= sticky_d;
      collision_q <= collision_d;
    end
  end

  assign color_enum = color_q;
  assign pix_valid  = pv_q;
  assign collision  = collision_q;

`ifdef FB_OWNER_EN
  logic [2:0] owner_d, owner_q;

  // Trail owner of the frame pixel; zero outside the active region.
  always_comb begin
    owner_d = '0;
    if (de1_q) begin
      for (int p = int'(NUM_PLAYERS) - 1; p >= 0; p--) begin
        if (frame_pix == PIX_BITS'(COL_TRAIL[p])) owner_d = 3'(p + 1);
      end
    end
  end

  // Owner output register, aligned with color_enum.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) owner_q <= '0;
    else        owner_q <= owner_d;
  end

  assign owner = owner_q;
`else
  assign owner = '0;
`endif

endmodule

// File: tb/tb_fb_compositor.sv
// Directed self-checking bench for fb_compositor (default parameters).
module tb_fb_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_clk;
  logic [9:0]  draw_x, draw_y;
  logic        de;
  logic [1:0]  bike_hit;
  logic [7:0]  bike_enum;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_pix_addr;
  logic [3:0]  wr_pix;
  logic [3:0]  color_enum;
  logic        pix_valid;
  logic [1:0]  collision;
  logic [2:0]  owner;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fb_compositor u_dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .frame_clk   (frame_clk),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .de          (de),
    .bike_hit    (bike_hit),
    .bike_enum   (bike_enum),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_pix_addr (wr_pix_addr),
    .wr_pix      (wr_pix),
    .color_enum  (color_enum),
    .pix_valid   (pix_valid),
    .collision   (collision),
    .owner       (owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [18:0] addr, input logic [3:0] pix);
    wr_valid    = 1'b1;
    wr_pix_addr = addr;
    wr_pix      = pix;
    tick();
    wr_valid    = 1'b0;
  endtask

  // Present a scan position and wait out the 2-cycle latency.
  task automatic scan(input logic [9:0] x, input logic [1:0] hit, input logic [7:0] en);
    de       = 1'b1;
    draw_x   = x;
    draw_y   = '0;
    bike_hit = hit;
    bike_enum = en;
    tick(2);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
  endtask

  logic [2:0] exp_owner;

  initial begin
    rst_n = 1'b0; frame_clk = 1'b0; draw_x = '0; draw_y = '0; de = 1'b0;
    bike_hit = '0; bike_enum = '0; wr_valid = 1'b0; wr_pix_addr = '0; wr_pix = '0;
    tick(2);
    check("rst_color", color_enum, 0);
    check("rst_pv", pix_valid, 0);
    check("rst_coll", collision, 0);
    check("rst_owner", owner, 0);
    check("rst_ready", wr_ready, 1);
    rst_n = 1'b1;
    tick();

    // Blanked writes drain at once; pixel 4 shares pixel 5's word (lane mask).
    push(19'd5, 4'h3);
    push(19'd4, 4'h0);
    check("ready_drain", wr_ready, 1);
    tick(2);

    // Latency: nothing after one cycle, the pixel after two.
    de = 1'b1; draw_x = 10'd5;
    tick();
    check("pv_lat1", pix_valid, 0);
    tick();
    check("pv_lat2", pix_valid, 1);
    check("px5", color_enum, 4'h3);
    scan(10'd4, 2'b00, 8'h00);
    check("px4", color_enum, 4'h0);

    // FIFO fill while display owns the port.
    push(19'd10, 4'h1);
    push(19'd11, 4'h2);
    push(19'd12, 4'h4);
    check("ready_3", wr_ready, 1);
    push(19'd13, 4'h7);
    check("ready_full", wr_ready, 0);
    push(19'd14, 4'h9);
    check("ready_stall", wr_ready, 0);
    de = 1'b0;
    tick();
    check("ready_back", wr_ready, 1);
    tick(3);
    scan(10'd10, 2'b00, 8'h00);
    check("px10", color_enum, 4'h1);
    scan(10'd12, 2'b00, 8'h00);
    check("px12", color_enum, 4'h4);
    scan(10'd13, 2'b00, 8'h00);
    check("px13", color_enum, 4'h7);
    scan(10'd5, 2'b00, 8'h00);
    check("px5_kept", color_enum, 4'h3);

    // Single hit over background: overlay but no collision.
    scan(10'd4, 2'b01, 8'h0E);
    check("ovl_single", color_enum, 4'hE);
    bike_hit = '0;
    tick(2);
    frame_pulse();
    check("coll_none", collision, 2'b00);

    // Two bikes collide: lowest index wins the pixel, both flag.
    scan(10'd5, 2'b11, 8'hCA);
    check("ovl_prio", color_enum, 4'hA);
    bike_hit = '0;
    tick(2);
    frame_pulse();
    check("coll_both", collision, 2'b11);
    tick(2);
    check("coll_hold", collision, 2'b11);
    frame_pulse();
    check("coll_clear", collision, 2'b00);

    // Blanking forces colour 0 even with a hit.
    de = 1'b0; bike_hit = 2'b01; bike_enum = 8'h0E;
    tick(2);
    check("blank_color", color_enum, 0);
    check("blank_pv", pix_valid, 0);
    bike_hit = '0;

    // Wall and trail pixels.
    push(19'd20, 4'h8);
    push(19'd21, 4'h5);
    tick(2);
    scan(10'd20, 2'b10, 8'hB0);
    check("ovl_p1", color_enum, 4'hB);
    check("owner_wall", owner, 0);
    scan(10'd21, 2'b00, 8'h00);
    check("px21", color_enum, 4'h5);
`ifdef FB_OWNER_EN
    exp_owner = 3'd2;
`else
    exp_owner = 3'd0;
`endif
    check("owner_trail", owner, exp_owner);
    frame_pulse();
    check("coll_wall", collision, 2'b10);

    // Reset while the FIFO is draining.
    push(19'd30, 4'h1);
    push(19'd31, 4'h1);
    de = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_color", color_enum, 0);
    check("mid_pv", pix_valid, 0);
    check("mid_coll", collision, 0);
    check("mid_owner", owner, 0);
    check("mid_ready", wr_ready, 1);
    tick();
    rst_n = 1'b1;
    de = 1'b1; draw_x = '0;
    push(19'd40, 4'h1);
    push(19'd41, 4'h1);
    push(19'd42, 4'h1);
    check("empty_3", wr_ready, 1);
    push(19'd43, 4'h1);
    check("empty_4", wr_ready, 0);
    de = 1'b0;
    tick(4);

    // Out-of-range write is accepted and popped.
    push(19'd307200, 4'hF);
    check("oor_ready", wr_ready, 1);
    tick();
    de = 1'b1;
    push(19'd50, 4'h1);
    push(19'd51, 4'h1);
    push(19'd52, 4'h1);
    check("oor_3", wr_ready, 1);
    push(19'd53, 4'h1);
    check("oor_4", wr_ready, 0);
    de = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
